// File: rtl/dds_multi_core.sv
// dds_multi_core: multi-channel DDS register writer.
//
// Programs an AD9959-style DDS through an external byte serializer. After reset
// it writes CSR/FR1/CFR and pulses io_update. On each accepted load it writes
// only the channels whose tuning/amplitude words changed since the last update,
// then pulses io_update once.
//
// Parameters:
//   NUM_CH     number of DDS channels (1..4)
//   IOUPD_CYC  io_update high time in clock cycles (1..15)
// Ports:
//   clock, reset_n         rising-edge clock, synchronous active-low reset
//   ftw, asf               per-channel tuning words / amplitude scale factors
//   pow                    per-channel phase offsets (only with DDS_PHASE_EN)
//   vco_gain, clock_multiplier, dac_fscale   static init configuration
//   load / ready / dropped new-value request, idle flag, sticky lost-load flag
//   busy / trigger         serializer handshake
//   packs_to_send          byte count of the current transfer
//   data_input             right-aligned transfer payload
//   master_reset           held high from reset until the first transfer
//   io_update              DDS register latch strobe
// Build option: define DDS_PHASE_EN to add the pow port and CPOW0 writes.
module dds_multi_core #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned IOUPD_CYC = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [32*NUM_CH-1:0] ftw,
    input  logic [10*NUM_CH-1:0] asf,
`ifdef DDS_PHASE_EN
    input  logic [14*NUM_CH-1:0] pow,
`endif
    input  logic                 vco_gain,
    input  logic [4:0]           clock_multiplier,
    input  logic [1:0]           dac_fscale,
    input  logic                 load,
    output logic                 ready,
    output logic                 dropped,
    input  logic                 busy,
    output logic                 trigger,
    output logic [4:0]           packs_to_send,
    output logic [63:0]          data_input,
    output logic                 master_reset,
    output logic                 io_update
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [3:0] IOUPD_LAST = 4'(IOUPD_CYC - 1);

    typedef enum logic [3:0] {
        StReset, StInitCsr, StInitFr1, StInitCfr, StIdle, StScan, StChCsr, StChFtw,
`ifdef DDS_PHASE_EN
        StChPow,
`endif
        StChAsf, StIoupd, StWait
    } state_e;

    state_e              state_q, state_d, ret_q, ret_d;
    logic                phase_q, phase_d;  // 0: instruction byte, 1: data bytes
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                trigger_q, trigger_d;
    logic [4:0]          packs_q, packs_d;
    logic [63:0]         data_q, data_d;
    logic                master_reset_q, master_reset_d;
    logic                dropped_q, dropped_d;
    logic                primed_q, primed_d;  // a full write has happened since reset
    logic [NUM_CH-1:0]   ftw_dirty_q, ftw_dirty_d, asf_dirty_q, asf_dirty_d;

    logic [NUM_CH-1:0][31:0] shadow_ftw_q, last_ftw_q;
    logic [NUM_CH-1:0][9:0]  shadow_asf_q, last_asf_q;
`ifdef DDS_PHASE_EN
    logic [NUM_CH-1:0][13:0] shadow_pow_q, last_pow_q;
    logic [NUM_CH-1:0]       pow_dirty_q, pow_dirty_d;
`endif

    logic                load_accept, ioupd_done;
    logic [NUM_CH-1:0]   scan_ftw_dirty, scan_asf_dirty, scan_chan, chan_dirty;
    logic                scan_any, nxt_found;
    logic [CH_W-1:0]     scan_first, nxt_ch;
    state_e              after_csr, after_ftw, after_pow, after_asf;
    logic                reg_valid;
    logic [7:0]          reg_addr;
    logic [4:0]          reg_bytes;
    logic [63:0]         reg_data;
    state_e              reg_follow;

    assign load_accept = (state_q == StIdle) && load;
    assign ioupd_done  = (state_q == StIoupd) && (cnt_q == IOUPD_LAST);

    // Dirty detection against the last values committed by io_update.
    always_comb begin
        scan_ftw_dirty = '0;
        scan_asf_dirty = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            scan_ftw_dirty[k] = !primed_q || (shadow_ftw_q[k] != last_ftw_q[k]);
            scan_asf_dirty[k] = !primed_q || (shadow_asf_q[k] != last_asf_q[k]);
        end
        scan_chan = scan_ftw_dirty | scan_asf_dirty;
        chan_dirty = ftw_dirty_q | asf_dirty_q;
`ifdef DDS_PHASE_EN
        for (int k = 0; k < int'(NUM_CH); k++) begin
            scan_chan[k] = scan_chan[k] || !primed_q || (shadow_pow_q[k] != last_pow_q[k]);
        end
        chan_dirty = chan_dirty | pow_dirty_q;
`endif
    end

    // Lowest dirty channel at scan time, and next dirty channel above ch_q.
    always_comb begin
        scan_any   = |scan_chan;
        scan_first = '0;
        nxt_found  = 1'b0;
        nxt_ch     = '0;
        for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
            if (scan_chan[k]) begin
                scan_first = CH_W'(k);
            end
            if (chan_dirty[k] && (k > int'(ch_q))) begin
                nxt_found = 1'b1;
                nxt_ch    = CH_W'(k);
            end
        end
    end

    // Per-channel register chain: CSR -> FTW -> (POW) -> ASF, skipping clean ones.
    always_comb begin
        after_asf = nxt_found ? StChCsr : StIoupd;
        after_pow = asf_dirty_q[ch_q] ? StChAsf : after_asf;
`ifdef DDS_PHASE_EN
        after_ftw = pow_dirty_q[ch_q] ? StChPow : after_pow;
`else
        after_ftw = after_pow;
`endif
        after_csr = ftw_dirty_q[ch_q] ? StChFtw : after_ftw;
    end

    // Address, size and payload of the register written by the current state.
    always_comb begin
        reg_valid  = 1'b1;
        reg_addr   = 8'h00;
        reg_bytes  = 5'd0;
        reg_data   = '0;
        reg_follow = StIdle;
        case (state_q)
            StInitCsr: begin
                reg_addr = 8'h00; reg_bytes = 5'd1; reg_data = 64'h06;
                reg_follow = StInitFr1;
            end
            StInitFr1: begin
                reg_addr = 8'h01; reg_bytes = 5'd3;
                reg_data = {40'b0, vco_gain, clock_multiplier, 18'b0};
                reg_follow = StInitCfr;
            end
            StInitCfr: begin
                reg_addr = 8'h03; reg_bytes = 5'd3;
                reg_data = {54'b0, dac_fscale, 8'b0};
                reg_follow = StIoupd;
            end
            StChCsr: begin
                reg_addr = 8'h00; reg_bytes = 5'd1;
                reg_data = {56'b0, 8'h06 | (8'h10 << ch_q)};
                reg_follow = after_csr;
            end
            StChFtw: begin
                reg_addr = 8'h04; reg_bytes = 5'd4;
                reg_data = {32'b0, shadow_ftw_q[ch_q]};
                reg_follow = after_ftw;
            end
`ifdef DDS_PHASE_EN
            StChPow: begin
                reg_addr = 8'h05; reg_bytes = 5'd2;
                reg_data = {50'b0, shadow_pow_q[ch_q]};
                reg_follow = after_pow;
            end
`endif
            StChAsf: begin
                reg_addr = 8'h06; reg_bytes = 5'd3;
                reg_data = {40'b0, 11'b0, 1'b1, 2'b0, shadow_asf_q[ch_q]};
                reg_follow = after_asf;
            end
            default: reg_valid = 1'b0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        ret_d          = ret_q;
        phase_d        = phase_q;
        ch_d           = ch_q;
        cnt_d          = '0;
        trigger_d      = 1'b0;
        packs_d        = packs_q;
        data_d         = data_q;
        master_reset_d = master_reset_q;
        dropped_d      = dropped_q | (load && (state_q != StIdle));
        primed_d       = primed_q;
        ftw_dirty_d    = ftw_dirty_q;
        asf_dirty_d    = asf_dirty_q;
`ifdef DDS_PHASE_EN
        pow_dirty_d    = pow_dirty_q;
`endif
        if (reg_valid) begin
            trigger_d      = 1'b1;
            master_reset_d = 1'b0;
            state_d        = StWait;
            if (!phase_q) begin
                packs_d = 5'd1;
                data_d  = {56'b0, reg_addr};
                ret_d   = state_q;
                phase_d = 1'b1;
            end else begin
                packs_d = reg_bytes;
                data_d  = reg_data;
                ret_d   = reg_follow;
                phase_d = 1'b0;
                // Last register of a channel: move on to the next dirty one.
                if (reg_follow == StChCsr) begin
                    ch_d = nxt_ch;
                end
            end
        end else begin
            case (state_q)
                StReset: state_d = StInitCsr;
                StIdle:  if (load) state_d = StScan;
                StScan: begin
                    ftw_dirty_d = scan_ftw_dirty;
                    asf_dirty_d = scan_asf_dirty;
`ifdef DDS_PHASE_EN
                    for (int k = 0; k < int'(NUM_CH); k++) begin
                        pow_dirty_d[k] = !primed_q || (shadow_pow_q[k] != last_pow_q[k]);
                    end
`endif
                    primed_d = 1'b1;
                    ch_d     = scan_first;
                    phase_d  = 1'b0;
                    state_d  = scan_any ? StChCsr : StIdle;
                end
                StIoupd: begin
                    cnt_d = cnt_q + 4'd1;
                    if (ioupd_done) state_d = StIdle;
                end
                // The previous trigger must be gone and the serializer idle.
                StWait:  if (!trigger_q && !busy) state_d = ret_q;
                default: state_d = StReset;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q        <= StReset;
            ret_q          <= StReset;
            phase_q        <= 1'b0;
            ch_q           <= '0;
            cnt_q          <= '0;
            trigger_q      <= 1'b0;
            packs_q        <= '0;
            data_q         <= '0;
            master_reset_q <= 1'b1;
            dropped_q      <= 1'b0;
            primed_q       <= 1'b0;
            ftw_dirty_q    <= '0;
            asf_dirty_q    <= '0;
            shadow_ftw_q   <= '0;
            shadow_asf_q   <= '0;
            last_ftw_q     <= '0;
            last_asf_q     <= '0;
`ifdef DDS_PHASE_EN
            pow_dirty_q    <= '0;
            shadow_pow_q   <= '0;
            last_pow_q     <= '0;
`endif
        end else begin
            state_q        <= state_d;
            ret_q          <= ret_d;
            phase_q        <= phase_d;
            ch_q           <= ch_d;
            cnt_q          <= cnt_d;
            trigger_q      <= trigger_d;
            packs_q        <= packs_d;
            data_q         <= data_d;
            master_reset_q <= master_reset_d;
            dropped_q      <= dropped_d;
            primed_q       <= primed_d;
            ftw_dirty_q    <= ftw_dirty_d;
            asf_dirty_q    <= asf_dirty_d;
`ifdef DDS_PHASE_EN
            pow_dirty_q    <= pow_dirty_d;
            if (load_accept) shadow_pow_q <= pow;
            if (ioupd_done)  last_pow_q   <= shadow_pow_q;
`endif
            if (load_accept) begin
                shadow_ftw_q <= ftw;
                shadow_asf_q <= asf;
            end
            if (ioupd_done) begin
                last_ftw_q <= shadow_ftw_q;
                last_asf_q <= shadow_asf_q;
            end
        end
    end

    assign ready         = (state_q == StIdle);
    assign io_update     = (state_q == StIoupd);
    assign dropped       = dropped_q;
    assign trigger       = trigger_q;
    assign packs_to_send = packs_q;
    assign data_input    = data_q;
    assign master_reset  = master_reset_q;

endmodule

// File: tb/tb_dds_multi_core.sv
module tb_dds_multi_core;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] ftw = '0;
    logic [19:0] asf = '0;
    logic        vco_gain = 1'b0;
    logic [4:0]  clock_multiplier = '0;
    logic [1:0]  dac_fscale = '0;
    logic        load = 1'b0;
    logic        ready, dropped, trigger, master_reset, io_update;
    logic        busy = 1'b0;
    logic [4:0]  packs_to_send;
    logic [63:0] data_input;

    int errors = 0;
    int checks = 0;

    logic [68:0] xq[$];     // observed transfers {packs, data}
    logic [68:0] exp_q[$];  // expected transfers for the current step
    int   io_cnt = 0;
    int   io_pulses = 0;
    logic io_prev = 1'b0;
    int   bcnt = 0;

    dds_multi_core #(.NUM_CH(2), .IOUPD_CYC(4)) dut (
        .clock(clock), .reset_n(reset_n), .ftw(ftw), .asf(asf),
        .vco_gain(vco_gain), .clock_multiplier(clock_multiplier), .dac_fscale(dac_fscale),
        .load(load), .ready(ready), .dropped(dropped), .busy(busy), .trigger(trigger),
        .packs_to_send(packs_to_send), .data_input(data_input),
        .master_reset(master_reset), .io_update(io_update)
    );

    always #5 clock = ~clock;

    // Transfer/io_update monitor and serializer model: busy for 2 cycles per trigger.
    always @(negedge clock) begin
        if (trigger) xq.push_back({packs_to_send, data_input});
        if (io_update) io_cnt++;
        if (io_update && !io_prev) io_pulses++;
        io_prev = io_update;
        if (trigger) bcnt = 2;
        else if (bcnt > 0) bcnt--;
        busy = (bcnt > 0);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_reg(input logic [7:0] addr, input logic [4:0] n, input logic [63:0] d);
        exp_q.push_back({5'd1, 56'b0, addr});
        exp_q.push_back({n, d});
    endtask

    task automatic push_ch(input logic [7:0] csr, input logic [31:0] f, input logic [9:0] a);
        push_reg(8'h00, 5'd1, {56'b0, csr});
        push_reg(8'h04, 5'd4, {32'b0, f});
        push_reg(8'h06, 5'd3, {40'b0, 11'b0, 1'b1, 2'b0, a});
    endtask

    task automatic push_init();
        push_reg(8'h00, 5'd1, 64'h06);
        push_reg(8'h01, 5'd3, 64'hD0_0000);
        push_reg(8'h03, 5'd3, 64'h300);
    endtask

    task automatic chk_xfers(input string tag, input int base);
        logic [68:0] obs;
        chk({tag, " count"}, 128'(xq.size() - base), 128'(exp_q.size()));
        foreach (exp_q[i]) begin
            obs = '0;
            if (base + i < xq.size()) obs = xq[base + i];
            chk($sformatf("%s xfer%0d", tag, i), 128'(obs), 128'(exp_q[i]));
        end
        exp_q.delete();
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!ready && n < 500) begin
            @(negedge clock);
            #1;
            n++;
        end
        chk(tag, 128'(ready), 128'(1'b1));
    endtask

    task automatic pulse_load();
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " trigger"}, 128'(trigger), 128'(0));
        chk({tag, " packs"}, 128'(packs_to_send), 128'(0));
        chk({tag, " data"}, 128'(data_input), 128'(0));
        chk({tag, " io_update"}, 128'(io_update), 128'(0));
        chk({tag, " ready"}, 128'(ready), 128'(0));
        chk({tag, " dropped"}, 128'(dropped), 128'(0));
        chk({tag, " master_reset"}, 128'(master_reset), 128'(1));
    endtask

    int base, io_base, pulse_base, n;

    initial begin
        vco_gain = 1'b1;
        clock_multiplier = 5'h14;
        dac_fscale = 2'b11;
        repeat (3) @(negedge clock);
        chk_reset_outputs("reset");

        // Init sequence
        base = xq.size(); io_base = io_cnt; pulse_base = io_pulses;
        reset_n = 1'b1;
        @(negedge clock);
        chk("mr before trigger", 128'(master_reset), 128'(1));
        chk("no early trigger", 128'(trigger), 128'(0));
        @(negedge clock);
        chk("first trigger", 128'(trigger), 128'(1));
        chk("mr falls", 128'(master_reset), 128'(0));
        wait_ready("init ready");
        push_init();
        chk_xfers("init", base);
        chk("init io cycles", 128'(io_cnt - io_base), 128'(4));
        chk("init io pulses", 128'(io_pulses - pulse_base), 128'(1));
        chk("dropped after init", 128'(dropped), 128'(0));

        // First load: everything dirty; inputs change and a load arrives mid-sequence
        base = xq.size(); io_base = io_cnt; pulse_base = io_pulses;
        ftw = {32'h2, 32'h1};
        asf = {10'h100, 10'h3FF};
        pulse_load();
        ftw = '1;
        asf = '1;
        repeat (3) @(negedge clock);
        pulse_load();
        chk("dropped set", 128'(dropped), 128'(1));
        ftw = {32'h2, 32'h1};
        asf = {10'h100, 10'h3FF};
        wait_ready("load1 ready");
        push_ch(8'h16, 32'h1, 10'h3FF);
        push_ch(8'h26, 32'h2, 10'h100);
        chk_xfers("load1", base);
        chk("load1 io cycles", 128'(io_cnt - io_base), 128'(4));
        chk("load1 io pulses", 128'(io_pulses - pulse_base), 128'(1));
        chk("dropped sticky", 128'(dropped), 128'(1));

        // Only ftw[1] changes
        base = xq.size(); io_base = io_cnt; pulse_base = io_pulses;
        ftw = {32'h5, 32'h1};
        pulse_load();
        wait_ready("load2 ready");
        push_reg(8'h00, 5'd1, 64'h26);
        push_reg(8'h04, 5'd4, 64'h5);
        chk_xfers("load2", base);
        chk("load2 io pulses", 128'(io_pulses - pulse_base), 128'(1));

        // Identical load: nothing written
        base = xq.size(); pulse_base = io_pulses;
        pulse_load();
        chk("same load busy", 128'(ready), 128'(0));
        @(negedge clock);
        chk("same load ready", 128'(ready), 128'(1));
        repeat (5) @(negedge clock);
        #1;
        chk("same load xfers", 128'(xq.size() - base), 128'(0));
        chk("same load io", 128'(io_pulses - pulse_base), 128'(0));

        // Reset while channel 1 FTW write is pending
        base = xq.size();
        ftw = {32'h7, 32'h1};
        pulse_load();
        n = 0;
        while ((xq.size() - base) < 3 && n < 500) begin
            @(negedge clock);
            #1;
            n++;
        end
        chk("reach ch1 ftw", 128'(xq.size() - base), 128'(3));
        reset_n = 1'b0;
        @(negedge clock);
        chk_reset_outputs("midreset");
        base = xq.size();
        reset_n = 1'b1;
        wait_ready("reinit ready");
        push_init();
        chk_xfers("reinit", base);

        base = xq.size(); pulse_base = io_pulses;
        pulse_load();
        wait_ready("load3 ready");
        push_ch(8'h16, 32'h1, 10'h3FF);
        push_ch(8'h26, 32'h7, 10'h100);
        chk_xfers("load3", base);
        chk("load3 io pulses", 128'(io_pulses - pulse_base), 128'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
